// File: rtl/cache_pkg.sv
// Shared constants and types for the cache controller and its backing memory.
// Block geometry: 32-bit words, 16 words per 512-bit block.
package cache_pkg;
    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_DATA_WIDTH = 512;
    localparam int BLOCK_OFFSET     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } mem_state_t;

    typedef logic [BLOCK_DATA_WIDTH-1:0] block_t;
endpackage

// File: rtl/block_ram.sv
// Single-port block array: synchronous write, synchronous read into an output register.
// Latency: one edge for read or write; no backpressure, the caller owns sequencing.
// Reset clears only the read register; array contents are left untouched.
module block_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = cache_pkg::BLOCK_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/main_memory_responder.sv
// Block-level main memory answering the cache controller's request port.
// Latency: ready pulses LATENCY edges after accept; requests are ignored while busy.
module main_memory_responder #(
    parameter int WORD_SIZE        = cache_pkg::WORD_SIZE,
    parameter int BLOCK_DATA_WIDTH = cache_pkg::BLOCK_DATA_WIDTH,
    parameter int BLOCK_OFFSET     = cache_pkg::BLOCK_OFFSET,
    parameter int INDEX_BITS       = 8,
    parameter int LATENCY          = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_req_enable,
    input  logic                        mem_req_rw,
    input  logic [WORD_SIZE-1:0]        mem_req_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_wdata,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_rdata,
    output logic                        mem_req_ready,
    output logic                        busy
);
    import cache_pkg::*;

    localparam int IDX_LO = BLOCK_OFFSET + 2;

    mem_state_t                  state_q;
    logic [7:0]                  cnt_q;
    logic                        rw_q;
    logic [INDEX_BITS-1:0]       idx_q;
    logic [BLOCK_DATA_WIDTH-1:0] wdata_q;
    logic                        ready_q;
    logic                        busy_q;

    logic done;
    logic ram_we;
    logic ram_re;
    logic addr_unused;

    // Byte/word offset and aliased upper bits never reach the array.
    assign addr_unused = ^{mem_req_addr[WORD_SIZE-1:IDX_LO+INDEX_BITS], mem_req_addr[IDX_LO-1:0]};

    assign done   = (state_q == BUSY) && (cnt_q == 8'd0);
    // A reset on the commit edge discards the pending write.
    assign ram_we = done && rw_q && !rst;
    assign ram_re = done && !rw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    busy_q  <= mem_req_enable;
                    if (mem_req_enable) begin
                        state_q <= BUSY;
                        rw_q    <= mem_req_rw;
                        idx_q   <= mem_req_addr[IDX_LO +: INDEX_BITS];
                        wdata_q <= mem_req_wdata;
                        cnt_q   <= 8'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= RESPOND;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    block_ram #(
        .ADDR_W (INDEX_BITS),
        .DATA_W (BLOCK_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_req_rdata)
    );

    assign mem_req_ready = ready_q;
    assign busy          = busy_q;
endmodule
